bcp_pe: RTL and testbench

//  Boolean-constraint-propagation processing element for the SAT accelerator. Holds one clause
//  and applies each decision literal to it: falsified literals are pruned, and the clause is

---
 rtl/bcp_pkg.sv | 23 ++
 rtl/bcp_pe_if.sv | 28 ++
 rtl/bcp_lit_cmp.sv | 20 ++
 rtl/bcp_pe.sv | 88 ++++++++
 tb/tb_bcp_pe.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/bcp_pkg.sv
// Shared types for the BCP processing element: signed literals and fixed-width clauses.
// Latency: n/a (types and a combinational helper only).
// Backpressure: n/a.
package bcp_pkg;

    localparam int LIT_INDEX_MAX = 1024;
    localparam int CLA_LENGTH    = 3;
    localparam int LIT_W         = $clog2(LIT_INDEX_MAX) + 1;
    localparam int CNT_W         = $clog2(CLA_LENGTH + 1);

    typedef logic signed [LIT_W-1:0] lit_t;
    typedef lit_t [CLA_LENGTH-1:0]   clause_t;
    typedef logic [CNT_W-1:0]        cnt_t;

    function automatic cnt_t count_nonzero(input clause_t c);
        cnt_t n = '0;
        for (int s = 0; s < CLA_LENGTH; s++) begin
            if (c[s] != '0) n = n + cnt_t'(1);
        end
        return n;
    endfunction

endpackage

// File: rtl/bcp_pe_if.sv
// Clause-load / decision-literal bus between the trail logic (master) and a BCP PE (slave).
// Latency: n/a (wiring only).
// Backpressure: none; the PE accepts a literal every cycle.
interface bcp_pe_if;
    import bcp_pkg::*;

    logic    clause_load;
    clause_t clause;
    logic    lit_valid;
    lit_t    litDec;
    logic    out_valid;
    clause_t pr_clause;
    logic    imply;
    lit_t    imply_idx;
    logic    done;
    logic    conflict;

    modport master (
        output clause_load, clause, lit_valid, litDec,
        input  out_valid, pr_clause, imply, imply_idx, done, conflict
    );

    modport slave (
        input  clause_load, clause, lit_valid, litDec,
        output out_valid, pr_clause, imply, imply_idx, done, conflict
    );

endinterface

// File: rtl/bcp_lit_cmp.sv
// Compares one clause slot against a decision literal: satisfied or falsified.
// Latency: combinational.
// Backpressure: none.
module bcp_lit_cmp
    import bcp_pkg::*;
(
    input  lit_t lit,
    input  lit_t dec,
    output logic sat,
    output logic falsified
);

    lit_t neg_dec;

    assign neg_dec   = -dec;
    // An empty slot (0) can never equal -dec for a nonzero dec, so it is never pruned.
    assign sat       = (dec != '0) && (lit == dec);
    assign falsified = (dec != '0) && (lit == neg_dec);

endmodule

// File: rtl/bcp_pe.sv
// Holds one clause, prunes it with each decision literal and reports done/imply/conflict.
// Latency: 1 cycle from clause_load or lit_valid to registered outputs and out_valid.
// Backpressure: none; a literal may arrive every cycle.
module bcp_pe
    import bcp_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    bcp_pe_if.slave  bus
);

    clause_t clause_q;
    logic    imply_q;
    lit_t    imply_idx_q;
    logic    done_q;
    logic    conflict_q;
    logic    out_valid_q;

    clause_t                 base_clause;
    logic                    base_done;
    logic                    base_conflict;
    logic                    apply;
    logic                    update;
    logic [CLA_LENGTH-1:0]   sat;
    logic [CLA_LENGTH-1:0]   falsified;
    clause_t                 next_clause;
    cnt_t                    nz_cnt;
    lit_t                    sel_lit;
    logic                    next_done;

    // A load replaces the held clause and clears the sticky flags before any same-cycle literal.
    assign base_clause   = bus.clause_load ? bus.clause : clause_q;
    assign base_done     = bus.clause_load ? 1'b0 : done_q;
    assign base_conflict = bus.clause_load ? 1'b0 : conflict_q;
    assign apply         = bus.lit_valid && (bus.litDec != '0) && !base_done && !base_conflict;
    assign update        = bus.clause_load || apply;

    for (genvar s = 0; s < CLA_LENGTH; s++) begin : g_slot
        bcp_lit_cmp u_cmp (
            .lit       (base_clause[s]),
            .dec       (bus.litDec),
            .sat       (sat[s]),
            .falsified (falsified[s])
        );
    end

    always_comb begin
        next_clause = base_clause;
        sel_lit     = '0;
        for (int s = 0; s < CLA_LENGTH; s++) begin
            if (apply && falsified[s]) next_clause[s] = '0;
        end
        next_done = base_done || (apply && (|sat));
        nz_cnt    = count_nonzero(next_clause);
        // Only consumed when exactly one slot is nonzero, so OR-ing all slots selects it.
        for (int s = 0; s < CLA_LENGTH; s++) begin
            sel_lit = sel_lit | next_clause[s];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clause_q    <= '0;
            imply_q     <= 1'b0;
            imply_idx_q <= '0;
            done_q      <= 1'b0;
            conflict_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= bus.clause_load || bus.lit_valid;
            if (update) begin
                clause_q    <= next_clause;
                done_q      <= next_done;
                imply_q     <= !next_done && (nz_cnt == cnt_t'(1));
                imply_idx_q <= (!next_done && (nz_cnt == cnt_t'(1))) ? sel_lit : '0;
                conflict_q  <= !next_done && (nz_cnt == '0);
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.pr_clause = clause_q;
    assign bus.imply     = imply_q;
    assign bus.imply_idx = imply_idx_q;
    assign bus.done      = done_q;
    assign bus.conflict  = conflict_q;

endmodule

// File: tb/tb_bcp_pe.sv
// Directed-vector scoreboard bench for bcp_pe: stimulus pushes expected status, a monitor pops on out_valid.
// Latency: n/a.
// Backpressure: n/a.
module tb_bcp_pe;
    import bcp_pkg::*;

    typedef struct {
        clause_t pr;
        logic    imply;
        lit_t    idx;
        logic    done;
        logic    conflict;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    bcp_pe_if bus ();

    bcp_pe dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t  exp_q[$];
    string name_q[$];
    int    tests_run = 0;
    int    tests_failed = 0;

    function automatic clause_t mk(input int a, input int b, input int c);
        clause_t r;
        r[2] = lit_t'(a);
        r[1] = lit_t'(b);
        r[0] = lit_t'(c);
        return r;
    endfunction

    task automatic issue(input string nm, input logic ld, input clause_t cl, input logic lv,
                         input int lit, input clause_t pr, input logic im, input int idx,
                         input logic dn, input logic cf);
        exp_t e;
        bus.clause_load = ld;
        bus.clause      = cl;
        bus.lit_valid   = lv;
        bus.litDec      = lit_t'(lit);
        e.pr       = pr;
        e.imply    = im;
        e.idx      = lit_t'(idx);
        e.done     = dn;
        e.conflict = cf;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
        bus.clause_load = 1'b0;
        bus.clause      = '0;
        bus.lit_valid   = 1'b0;
        bus.litDec      = '0;
    endtask

    task automatic check_zero(input string nm);
        tests_run++;
        if (bus.out_valid !== 1'b0 || bus.pr_clause !== '0 || bus.imply !== 1'b0 ||
            bus.imply_idx !== '0 || bus.done !== 1'b0 || bus.conflict !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s: got vld=%b pr=%h imply=%b idx=%0d done=%b conflict=%b, want all zero",
                     nm, bus.out_valid, bus.pr_clause, bus.imply, bus.imply_idx, bus.done, bus.conflict);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t  e;
        string nm;
        if (rst_n && bus.out_valid === 1'b1) begin
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL unexpected_out_valid: got out_valid=1, want no response pending");
            end else begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                if (bus.pr_clause !== e.pr || bus.imply !== e.imply || bus.imply_idx !== e.idx ||
                    bus.done !== e.done || bus.conflict !== e.conflict) begin
                    tests_failed++;
                    $display("FAIL %s: got pr=%h imply=%b idx=%0d done=%b conflict=%b, want pr=%h imply=%b idx=%0d done=%b conflict=%b",
                             nm, bus.pr_clause, bus.imply, bus.imply_idx, bus.done, bus.conflict,
                             e.pr, e.imply, e.idx, e.done, e.conflict);
                end
            end
        end
    end

    initial begin
        bus.clause_load = 1'b0;
        bus.clause      = '0;
        bus.lit_valid   = 1'b0;
        bus.litDec      = '0;

        #12;
        check_zero("reset_state");
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Implication
        issue("imp_load", 1, mk(0,12,-7), 0, 0,   mk(0,12,-7), 0, 0,  0, 0);
        issue("imp_lit7", 0, '0,          1, 7,   mk(0,12,0),  1, 12, 0, 0);
        // Successive pruning, back-to-back literals
        issue("prn_load", 1, mk(5,-9,3),  0, 0,   mk(5,-9,3),  0, 0,  0, 0);
        issue("prn_m5",   0, '0,          1, -5,  mk(0,-9,3),  0, 0,  0, 0);
        issue("prn_m3",   0, '0,          1, -3,  mk(0,-9,0),  1, -9, 0, 0);
        // Conflict and stickiness
        issue("cfl_load", 1, mk(0,0,4),   0, 0,   mk(0,0,4),   1, 4,  0, 0);
        issue("cfl_m4",   0, '0,          1, -4,  mk(0,0,0),   0, 0,  0, 1);
        issue("cfl_stky", 0, '0,          1, 6,   mk(0,0,0),   0, 0,  0, 1);
        // Satisfied and stickiness
        issue("sat_load", 1, mk(5,-9,3),  0, 0,   mk(5,-9,3),  0, 0,  0, 0);
        issue("sat_m9",   0, '0,          1, -9,  mk(5,-9,3),  0, 0,  1, 0);
        issue("sat_stky", 0, '0,          1, -5,  mk(5,-9,3),  0, 0,  1, 0);
        // Non-matching and zero literal
        issue("nm_load",  1, mk(5,-9,3),  0, 0,   mk(5,-9,3),  0, 0,  0, 0);
        issue("nm_100",   0, '0,          1, 100, mk(5,-9,3),  0, 0,  0, 0);
        issue("nm_zero",  0, '0,          1, 0,   mk(5,-9,3),  0, 0,  0, 0);
        // Tautology: done wins, falsified twin still pruned
        issue("tau_load", 1, mk(2,-2,7),  0, 0,   mk(2,-2,7),  0, 0,  0, 0);
        issue("tau_m2",   0, '0,          1, -2,  mk(0,-2,7),  0, 0,  1, 0);
        // Duplicate literals pruned together
        issue("dup_load", 1, mk(6,6,-1),  0, 0,   mk(6,6,-1),  0, 0,  0, 0);
        issue("dup_m6",   0, '0,          1, -6,  mk(0,0,-1),  1, -1, 0, 0);
        // Empty clause loads as conflict
        issue("empty",    1, mk(0,0,0),   0, 0,   mk(0,0,0),   0, 0,  0, 1);
        // Load with same-cycle literal clears sticky done
        issue("ld_load",  1, mk(1,2,3),   0, 0,   mk(1,2,3),   0, 0,  0, 0);
        issue("ld_p1",    0, '0,          1, 1,   mk(1,2,3),   0, 0,  1, 0);
        issue("ld_both",  1, mk(0,-4,5),  1, 4,   mk(0,0,5),   1, 5,  0, 0);

        // Asynchronous reset mid-stream
        issue("rst_load", 1, mk(5,-9,3),  0, 0,   mk(5,-9,3),  0, 0,  0, 0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async_reset");
        #3;
        rst_n = 1'b1;
        issue("rst_both", 1, mk(0,0,8),   1, -8,  mk(0,0,0),   0, 0,  0, 1);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL drain_timeout: got %0d responses pending, want 0", exp_q.size());
        end
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
